// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: word-addressed 32-bit data RAM behind a req/ready handshake with programmable wait states
module data_ram_ctrl #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        req,
  input  logic        RW,
  input  logic [31:0] address,
  input  logic [31:0] RAM_in,
  output logic [31:0] RAM_out,
  output logic        ready,
  output logic        busy,
  output logic        addr_err
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  logic [1:0]            state, nxt;
  logic [3:0]            cnt;
  logic                  rw_q, err_q;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic [31:0]           data_q;
  logic [31:0]           mem [0:(1 << DEPTH_LOG2) - 1];
  logic                  in_err, cur_rw, cur_err, go_resp;
  logic [DEPTH_LOG2-1:0] cur_addr;
  logic [31:0]           cur_data;
  assign in_err = |address[31:DEPTH_LOG2];
  // with zero wait states the access completes on the accept edge, so the live inputs stand in for the latched copies
  assign cur_rw   = (state == IDLE) ? RW : rw_q;
  assign cur_err  = (state == IDLE) ? in_err : err_q;
  assign cur_addr = (state == IDLE) ? address[DEPTH_LOG2-1:0] : addr_q;
  assign cur_data = (state == IDLE) ? RAM_in : data_q;
  assign go_resp  = !Reset && nxt == RESP;
  // next-state selection for IDLE -> WAIT -> RESP -> IDLE
  always_comb begin
    nxt = IDLE;
    nxt = (state == IDLE) ? (req ? ((WAIT_STATES == 0) ? RESP : WAIT) : IDLE) :
          (state == WAIT) ? ((cnt == 4'd0) ? RESP : WAIT) : IDLE;
  end
  // control state, handshake outputs and read data register
  always_ff @(posedge clk) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      addr_err <= 1'b0;
      RAM_out  <= 32'd0;
    end else begin
      state    <= nxt;
      busy     <= nxt != IDLE;
      ready    <= nxt == RESP;
      addr_err <= nxt == RESP && cur_err;
      if (state == IDLE) cnt <= CNT_INIT;
      else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (go_resp && cur_err) RAM_out <= 32'd0;
      else if (go_resp && cur_rw) RAM_out <= mem[cur_addr];
    end
  end
  // capture the request on accept so later input changes cannot disturb it
  always_ff @(posedge clk) begin
    if (!Reset && state == IDLE && req) begin
      rw_q   <= RW;
      err_q  <= in_err;
      addr_q <= address[DEPTH_LOG2-1:0];
      data_q <= RAM_in;
    end
  end
  // array write commits only on RESP entry, so a reset during WAIT drops it
  always_ff @(posedge clk) begin
    if (go_resp && !cur_rw && !cur_err) mem[cur_addr] <= cur_data;
  end
endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb_data_ram_ctrl: scoreboard bench for data_ram_ctrl with a 2-wait-state and a 0-wait-state instance
module tb_data_ram_ctrl;
  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic [1:0]  req = 2'b00;
  logic        RW = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] RAM_in = 32'd0;
  logic [31:0] rout [2];
  logic [1:0]  rdy, bsy, aerr;
  typedef struct {
    int          tag;
    logic [31:0] data;
    logic        err;
    int          acc;
  } txn_t;
  txn_t        q[$];
  int          st [2];
  int          cnt [2];
  int          cyc = 0;
  logic [31:0] mem [2][256];
  logic [31:0] mout [2];
  logic        prw [2];
  logic        perr [2];
  logic [7:0]  pa [2];
  logic [31:0] pd [2];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  data_ram_ctrl #(.DEPTH_LOG2(8), .WAIT_STATES(2)) dut (
    .clk(clk), .Reset(Reset), .req(req[0]), .RW(RW), .address(address), .RAM_in(RAM_in),
    .RAM_out(rout[0]), .ready(rdy[0]), .busy(bsy[0]), .addr_err(aerr[0]));
  data_ram_ctrl #(.DEPTH_LOG2(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .Reset(Reset), .req(req[1]), .RW(RW), .address(address), .RAM_in(RAM_in),
    .RAM_out(rout[1]), .ready(rdy[1]), .busy(bsy[1]), .addr_err(aerr[1]));

  function automatic int ws(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, i, $time, act, exp);
    end
  endtask

  task automatic commit(input int i);
    if (perr[i]) mout[i] = 32'd0;
    else if (prw[i]) mout[i] = mem[i][pa[i]];
    else mem[i][pa[i]] = pd[i];
  endtask

  // monitor at negedge, reference model at posedge, in one process so the scoreboard has a single owner
  initial begin
    mout[0] = 32'd0; mout[1] = 32'd0; st[0] = 0; st[1] = 0;
    forever begin
      @(negedge clk);
      if (!Reset) begin
        for (int i = 0; i < 2; i++) begin
          chk("busy", i, 32'(bsy[i]), 32'(st[i] != 0));
          chk("ready", i, 32'(rdy[i]), 32'(st[i] == 2));
          chk("ram_out", i, rout[i], mout[i]);
          if (st[i] == 2) begin
            int idx = -1;
            foreach (q[k]) if (idx < 0 && q[k].tag == i) idx = k;
            if (idx < 0) chk("sb_entry", i, 32'd0, 32'd1);
            else begin
              chk("resp_data", i, rout[i], q[idx].data);
              chk("resp_err", i, 32'(aerr[i]), 32'(q[idx].err));
              chk("latency", i, 32'(cyc - q[idx].acc), 32'(ws(i)));
              q.delete(idx);
            end
          end else chk("idle_err", i, 32'(aerr[i]), 32'd0);
        end
      end
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (Reset) begin
          st[i] = 0;
          mout[i] = 32'd0;
          for (int k = q.size() - 1; k >= 0; k--) if (q[k].tag == i) q.delete(k);
        end else if (st[i] == 0) begin
          if (req[i]) begin
            txn_t t;
            prw[i] = RW; perr[i] = |address[31:8]; pa[i] = address[7:0]; pd[i] = RAM_in;
            t.tag = i; t.err = perr[i]; t.acc = cyc;
            t.data = perr[i] ? 32'd0 : (RW ? mem[i][address[7:0]] : mout[i]);
            q.push_back(t);
            if (ws(i) == 0) begin commit(i); st[i] = 2; end
            else begin st[i] = 1; cnt[i] = ws(i) - 1; end
          end
        end else if (st[i] == 1) begin
          if (cnt[i] == 0) begin commit(i); st[i] = 2; end
          else cnt[i]--;
        end else st[i] = 0;
      end
    end
  end

  task automatic wait_idle(input int i);
    for (int k = 0; k < 40; k++) begin
      if (!bsy[i]) return;
      @(negedge clk);
    end
    $display("FAIL timeout dut%0d: busy still %0d expected 0", i, bsy[i]);
    $fatal(1, "timeout");
  endtask

  task automatic issue(input int i, input logic rw, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req[i] = 1'b1; RW = rw; address = a; RAM_in = d;
    @(negedge clk);
    req[i] = 1'b0;
    wait_idle(i);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", 0, 32'(rdy[0]), 32'd0);
    chk("rst_busy", 0, 32'(bsy[0]), 32'd0);
    chk("rst_ram_out", 0, rout[0], 32'd0);
    Reset = 1'b0;
    issue(0, 1'b0, 32'h10, 32'hDEADBEEF);
    issue(0, 1'b1, 32'h10, 32'h0);
    issue(0, 1'b0, 32'h0, 32'h12345678);
    issue(0, 1'b0, 32'h100, 32'hCAFEF00D);
    issue(0, 1'b1, 32'h0, 32'h0);
    issue(0, 1'b1, 32'hFFFF0003, 32'h0);
    issue(0, 1'b0, 32'h20, 32'h11112222);
    @(negedge clk);
    req[0] = 1'b1; RW = 1'b0; address = 32'h20; RAM_in = 32'hAAAA5555;
    @(negedge clk);
    req[0] = 1'b0; Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    issue(0, 1'b1, 32'h20, 32'h0);
    @(negedge clk);
    Reset = 1'b1; req[0] = 1'b1; RW = 1'b0; address = 32'h20; RAM_in = 32'h00000BAD;
    @(negedge clk);
    Reset = 1'b0; req[0] = 1'b0;
    issue(0, 1'b1, 32'h20, 32'h0);
    issue(0, 1'b0, 32'h1, 32'h01010101);
    issue(0, 1'b0, 32'h2, 32'h02020202);
    issue(0, 1'b0, 32'h3, 32'h03030303);
    @(negedge clk);
    req[0] = 1'b1; RW = 1'b1;
    for (int k = 0; k < 17; k++) begin
      address = 32'((k * 3) % 4);
      RAM_in = 32'(k);
      @(negedge clk);
    end
    req[0] = 1'b0;
    wait_idle(0);
    issue(1, 1'b0, 32'hFF, 32'h5A5A0FF0);
    @(negedge clk);
    req[1] = 1'b1; RW = 1'b1; address = 32'hFF;
    @(negedge clk);
    RW = 1'b0; address = 32'h80; RAM_in = 32'hFFFFFFFF;
    @(negedge clk);
    req[1] = 1'b0;
    wait_idle(1);
    issue(1, 1'b1, 32'hFF, 32'h0);
    issue(1, 1'b0, 32'h1FF, 32'h77777777);
    issue(1, 1'b1, 32'hFF, 32'h0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
